// File: rtl/tc_accum_mergetree_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tc_pkg
// Purpose  : Shared helpers for the accumulating merge tree: constant log2
//            and the FAN_IN / DW_ACC legality check.
// Revision : 1.0 - initial release
// ============================================================================
package tc_pkg;

   // Ceiling log2 usable in parameter/localparam context
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x * 2;
         r = r + 1;
      end
      return r;
   endfunction

   // FAN_IN must be a power of two >= 2 and the accumulator wide enough for a full tree sum
   function automatic bit params_ok(input int fan_in, input int dw_in, input int dw_acc);
      return (fan_in >= 2) && ((fan_in & (fan_in - 1)) == 0) &&
             (dw_acc >= dw_in + clog2(fan_in));
   endfunction

endpackage
`default_nettype wire

// File: rtl/tc_accum_mergetree_if.sv
`default_nettype none
// ============================================================================
// Module   : tc_accum_mergetree_if
// Purpose  : Beat/result bus between the multiplier array, the merge tree and
//            the output/psum buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface tc_accum_mergetree_if #(
   parameter int N_MERGE = 16,
   parameter int FAN_IN  = 4,
   parameter int DW_IN   = 32,
   parameter int DW_ACC  = 40
);
   logic                             in_stall;
   logic                             in_valid;
   logic                             in_first;
   logic                             in_last;
   logic [N_MERGE*FAN_IN*DW_IN-1:0]  in_mult;
   logic [N_MERGE*DW_ACC-1:0]        in_psum;
   logic                             out_valid;
   logic [N_MERGE*DW_ACC-1:0]        out;

   modport master (
      output in_stall, in_valid, in_first, in_last, in_mult, in_psum,
      input  out_valid, out
   );

   modport slave (
      input  in_stall, in_valid, in_first, in_last, in_mult, in_psum,
      output out_valid, out
   );
endinterface
`default_nettype wire

// File: rtl/tc_accum_mergetree_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : tc_adder_tree_p
// Purpose  : Registered binary adder tree reducing FAN_IN products to one
//            DW_ACC-wide sum, one register level per tree level.
// Revision : 1.0 - initial release
// ============================================================================
module tc_adder_tree_p #(
   parameter int FAN_IN = 4,
   parameter int DW_IN  = 32,
   parameter int DW_ACC = 40,
   parameter bit SIGNED = 1'b1
) (
   input  wire logic                      clk,
   input  wire logic                      reset_n,
   input  wire logic                      en,
   input  wire logic [FAN_IN*DW_IN-1:0]   in,
   output logic      [DW_ACC-1:0]         out
);
   // Heap layout: node 0 is the root, children of k are 2k+1 and 2k+2,
   // leaves occupy FAN_IN-1 .. 2*FAN_IN-2. All leaves sit at equal depth.
   logic [DW_ACC-1:0] w_tree [2*FAN_IN-1];

   for (genvar i = 0; i < FAN_IN; i++) begin : g_leaf
      logic w_ext_bit;
      assign w_ext_bit = SIGNED ? in[i*DW_IN + DW_IN - 1] : 1'b0;
      assign w_tree[FAN_IN-1+i] = {{(DW_ACC-DW_IN){w_ext_bit}}, in[i*DW_IN +: DW_IN]};
   end

   for (genvar k = 0; k < FAN_IN-1; k++) begin : g_node
      logic [DW_ACC-1:0] r_q;
      // One registered wrapping adder per internal node
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_q <= '0;
         end else if (en) begin
            r_q <= w_tree[2*k+1] + w_tree[2*k+2];
         end
      end
      assign w_tree[k] = r_q;
   end

   assign out = w_tree[0];
endmodule
`default_nettype wire

// File: rtl/tc_accum_mergetree.sv
`default_nettype none
// ============================================================================
// Module   : tc_accum_mergetree
// Purpose  : N_MERGE pipelined adder trees followed by per-lane accumulators
//            that merge a K-tile sequence seeded from an external psum and
//            emit the result on the last tile.
// Revision : 1.0 - initial release
// ============================================================================
module tc_accum_mergetree
   import tc_pkg::*;
#(
   parameter int N_MERGE = 16,
   parameter int FAN_IN  = 4,
   parameter int DW_IN   = 32,
   parameter int DW_ACC  = 40,
   parameter bit SIGNED  = 1'b1
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   tc_accum_mergetree_if.slave   bus
);
   localparam int D = clog2(FAN_IN);

   if (!params_ok(FAN_IN, DW_IN, DW_ACC)) begin : g_param_check
      $fatal(1, "tc_accum_mergetree: FAN_IN must be a power of two >= 2 and DW_ACC >= DW_IN+log2(FAN_IN)");
   end

   logic w_en;
   assign w_en = !bus.in_stall;

   logic [DW_ACC-1:0] w_tree [N_MERGE];

   for (genvar g = 0; g < N_MERGE; g++) begin : g_lane
      tc_adder_tree_p #(
         .FAN_IN (FAN_IN),
         .DW_IN  (DW_IN),
         .DW_ACC (DW_ACC),
         .SIGNED (SIGNED)
      ) u_tree (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (w_en),
         .in      (bus.in_mult[g*FAN_IN*DW_IN +: FAN_IN*DW_IN]),
         .out     (w_tree[g])
      );
   end

   logic [D-1:0]              r_vld_pipe;
   logic [D-1:0]              r_fst_pipe;
   logic [D-1:0]              r_lst_pipe;
   logic [N_MERGE*DW_ACC-1:0] r_psum_pipe [D];

   // Carry the beat's sideband and seed alongside the tree so they line up with its sum
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld_pipe <= '0;
         r_fst_pipe <= '0;
         r_lst_pipe <= '0;
         for (int i = 0; i < D; i++) r_psum_pipe[i] <= '0;
      end else if (w_en) begin
         r_vld_pipe[0]  <= bus.in_valid;
         r_fst_pipe[0]  <= bus.in_first;
         r_lst_pipe[0]  <= bus.in_last;
         r_psum_pipe[0] <= bus.in_psum;
         for (int i = 1; i < D; i++) begin
            r_vld_pipe[i]  <= r_vld_pipe[i-1];
            r_fst_pipe[i]  <= r_fst_pipe[i-1];
            r_lst_pipe[i]  <= r_lst_pipe[i-1];
            r_psum_pipe[i] <= r_psum_pipe[i-1];
         end
      end
   end

   logic w_aln_vld;
   logic w_aln_fst;
   logic w_aln_lst;
   assign w_aln_vld = r_vld_pipe[D-1];
   assign w_aln_fst = r_fst_pipe[D-1];
   assign w_aln_lst = r_lst_pipe[D-1];

   logic [DW_ACC-1:0]         r_acc     [N_MERGE];
   logic [DW_ACC-1:0]         w_acc_nxt [N_MERGE];
   logic [N_MERGE*DW_ACC-1:0] r_out;
   logic                      r_out_vld;
   logic                      r_seq_open;

   // First tile restarts from the seed, later tiles build on the running sum
   always_comb begin
      for (int g = 0; g < N_MERGE; g++) begin
         w_acc_nxt[g] = w_tree[g] +
                        (w_aln_fst ? r_psum_pipe[D-1][g*DW_ACC +: DW_ACC] : r_acc[g]);
      end
   end

   // Accumulate aligned beats; publish the sum only on the sequence's last tile
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int g = 0; g < N_MERGE; g++) r_acc[g] <= '0;
         r_out      <= '0;
         r_out_vld  <= 1'b0;
         r_seq_open <= 1'b0;
      end else if (w_en) begin
         r_out_vld <= w_aln_vld & w_aln_lst;
         if (w_aln_vld) begin
            for (int g = 0; g < N_MERGE; g++) r_acc[g] <= w_acc_nxt[g];
            if (w_aln_lst) begin
               for (int g = 0; g < N_MERGE; g++) r_out[g*DW_ACC +: DW_ACC] <= w_acc_nxt[g];
            end
            r_seq_open <= !w_aln_lst;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.out_valid = r_out_vld;

   // A published result always closes its sequence
   a_out_closes_seq: assert property (@(posedge clk) disable iff (!reset_n)
                                      r_out_vld |-> !r_seq_open);
endmodule
`default_nettype wire

// File: tb/tb_tc_accum_mergetree.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_accum_mergetree
// Purpose  : Self-checking bench for tc_accum_mergetree with directed cases
//            and randomized beats against a sequence-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_accum_mergetree;
   import tc_pkg::*;

   localparam int N_MERGE = 16;
   localparam int FAN_IN  = 4;
   localparam int DW_IN   = 32;
   localparam int DW_ACC  = 40;
   localparam int D       = clog2(FAN_IN);
   localparam int OW      = N_MERGE*DW_ACC;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   tc_accum_mergetree_if #(.N_MERGE(N_MERGE), .FAN_IN(FAN_IN), .DW_IN(DW_IN), .DW_ACC(DW_ACC)) bus ();

   tc_accum_mergetree #(
      .N_MERGE(N_MERGE), .FAN_IN(FAN_IN), .DW_IN(DW_IN), .DW_ACC(DW_ACC), .SIGNED(1'b1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [DW_IN-1:0]  prod  [N_MERGE][FAN_IN];
   logic [DW_ACC-1:0] psum  [N_MERGE];
   logic [DW_ACC-1:0] m_acc [N_MERGE];

   typedef struct {
      logic [OW-1:0] val;
      int            due;
   } exp_t;
   exp_t          q[$];
   int            n_edges = 0;
   logic          exp_vld = 1'b0;
   logic [OW-1:0] exp_out = '0;

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_all(input logic [DW_IN-1:0] p, input logic [DW_ACC-1:0] s);
      for (int g = 0; g < N_MERGE; g++) begin
         for (int f = 0; f < FAN_IN; f++) prod[g][f] = p;
         psum[g] = s;
      end
   endtask

   // One clock: present the beat, update the sequence model, then compare outputs
   task automatic step(input logic stall, input logic valid, input logic first, input logic last);
      logic [DW_ACC-1:0] sum;
      logic [OW-1:0]     packed_res;
      bus.in_stall = stall;
      if (!stall) begin
         bus.in_valid = valid;
         bus.in_first = first;
         bus.in_last  = last;
         for (int g = 0; g < N_MERGE; g++) begin
            for (int f = 0; f < FAN_IN; f++)
               bus.in_mult[(g*FAN_IN+f)*DW_IN +: DW_IN] = prod[g][f];
            bus.in_psum[g*DW_ACC +: DW_ACC] = psum[g];
         end
         n_edges++;
         if (valid) begin
            for (int g = 0; g < N_MERGE; g++) begin
               sum = '0;
               for (int f = 0; f < FAN_IN; f++)
                  sum = sum + {{(DW_ACC-DW_IN){prod[g][f][DW_IN-1]}}, prod[g][f]};
               m_acc[g] = sum + (first ? psum[g] : m_acc[g]);
               packed_res[g*DW_ACC +: DW_ACC] = m_acc[g];
            end
            if (last) q.push_back('{val: packed_res, due: n_edges + D});
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (!stall) begin
         if (q.size() > 0 && q[0].due == n_edges) begin
            exp_vld = 1'b1;
            exp_out = q[0].val;
            void'(q.pop_front());
         end else begin
            exp_vld = 1'b0;
         end
      end
      chk("out_valid", {{(OW-1){1'b0}}, bus.out_valid}, {{(OW-1){1'b0}}, exp_vld});
      chk("out", bus.out, exp_out);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic model_reset();
      for (int g = 0; g < N_MERGE; g++) m_acc[g] = '0;
      q.delete();
      exp_vld = 1'b0;
      exp_out = '0;
   endtask

   logic [63:0] t64;

   initial begin
      bus.in_stall = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_mult  = '0;
      bus.in_psum  = '0;
      set_all('0, '0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_out", bus.out, '0);
      chk("reset_valid", {{(OW-1){1'b0}}, bus.out_valid}, '0);
      reset_n = 1'b1;

      // Single tile: lane 0 products 1..4, psum 10 -> 20 after D+1 cycles
      set_all('0, '0);
      for (int f = 0; f < FAN_IN; f++) prod[0][f] = DW_IN'(f + 1);
      psum[0] = 40'd10;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);
      chk("single_lane0", {{(OW-DW_ACC){1'b0}}, bus.out[DW_ACC-1:0]}, OW'(20));
      idle(2);

      // Three-tile sequence, all products 1, psum 100 -> 112
      set_all(32'd1, 40'd100);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      idle(2);
      chk("three_tile_lane0", {{(OW-DW_ACC){1'b0}}, bus.out[DW_ACC-1:0]}, OW'(112));
      idle(2);

      // Signed wrap: four -1 products -> -4; psum all-ones plus 1 -> 0
      set_all(32'hFFFF_FFFF, '0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      set_all('0, {DW_ACC{1'b1}});
      for (int g = 0; g < N_MERGE; g++) prod[g][0] = 32'd1;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      idle(1);
      chk("signed_neg4", {{(OW-DW_ACC){1'b0}}, bus.out[DW_ACC-1:0]}, OW'(40'hFF_FFFF_FFFC));
      idle(1);
      chk("signed_wrap0", {{(OW-DW_ACC){1'b0}}, bus.out[DW_ACC-1:0]}, '0);
      idle(2);

      // Stall for two cycles after beat 1 with inputs held
      set_all(32'd1, 40'd100);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      idle(4);

      // Asynchronous reset mid-sequence, between clock edges
      set_all(32'd3, 40'd7);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      idle(1);
      #2;
      reset_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("async_out", bus.out, '0);
      chk("async_valid", {{(OW-1){1'b0}}, bus.out_valid}, '0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      set_all(32'd1, 40'd55);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      idle(2);
      chk("post_reset_lane0", {{(OW-DW_ACC){1'b0}}, bus.out[DW_ACC-1:0]}, OW'(4));
      idle(1);

      // Back-to-back single-tile sequences on every lane
      for (int g = 0; g < N_MERGE; g++) begin
         for (int f = 0; f < FAN_IN; f++) prod[g][f] = DW_IN'(g);
         psum[g] = '0;
      end
      step(1'b0, 1'b1, 1'b1, 1'b1);
      for (int g = 0; g < N_MERGE; g++) psum[g] = 40'd1;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      idle(1);
      chk("b2b_lane15_A", {{(OW-DW_ACC){1'b0}}, bus.out[15*DW_ACC +: DW_ACC]}, OW'(60));
      idle(1);
      chk("b2b_lane15_B", {{(OW-DW_ACC){1'b0}}, bus.out[15*DW_ACC +: DW_ACC]}, OW'(61));
      idle(2);

      // Randomized beats, stalls and sequence boundaries
      for (int c = 0; c < 300; c++) begin
         logic st;
         st = ($urandom_range(0, 4) == 0);
         if (!st) begin
            for (int g = 0; g < N_MERGE; g++) begin
               for (int f = 0; f < FAN_IN; f++) prod[g][f] = $urandom();
               t64 = {$urandom(), $urandom()};
               psum[g] = t64[DW_ACC-1:0];
            end
         end
         step(st, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0));
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
